// File: rtl/wfg_mem_pkg.sv
// Shared types and helpers for the wfg stimulus-memory path.
// Covers the merged 1024x32 memory and its request arbitration.
package wfg_mem_pkg;

  localparam int MEM_ADDR_W = 10;
  localparam int MEM_DATA_W = 32;
  localparam int MEM_BANK_W = 9;
  localparam int MAX_REQ    = 4;
  localparam int STAT_W     = 16;

  typedef logic [MEM_ADDR_W-1:0] mem_addr_t;
  typedef logic [MEM_DATA_W-1:0] mem_data_t;
  typedef logic [1:0]            req_idx_t;

  typedef struct packed {
    logic     valid;
    req_idx_t id;
  } inflight_t;

  function automatic logic [MAX_REQ-1:0] idx_to_onehot(input req_idx_t idx);
    logic [MAX_REQ-1:0] oh;
    oh      = {MAX_REQ{1'b0}};
    oh[idx] = 1'b1;
    return oh;
  endfunction

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == {STAT_W{1'b1}}) ? v : v + {{(STAT_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/wfg_rr_arbiter.sv
// Round-robin grant logic for up to four requesters.
// Searches upward from pointer+1 with wrap; pointer moves to the winner on each grant.
module wfg_rr_arbiter
  import wfg_mem_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output req_idx_t           grant_idx,
  output logic               grant_valid
);

  localparam req_idx_t LAST_IDX = req_idx_t'(NUM_REQ - 1);

  req_idx_t           ptr_r;
  logic [MAX_REQ-1:0] req_pad_s;
  logic [MAX_REQ-1:0] grant_pad_s;
  req_idx_t           idx_s;
  req_idx_t           cand_s;
  logic [2:0]         sum_s;
  logic               found_s;

  // first requesting index after the pointer, wrapping; reset also blocks grants
  always_comb begin
    req_pad_s              = {MAX_REQ{1'b0}};
    req_pad_s[NUM_REQ-1:0] = req;
    grant_pad_s            = {MAX_REQ{1'b0}};
    idx_s                  = 2'd0;
    cand_s                 = 2'd0;
    sum_s                  = 3'd0;
    found_s                = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      sum_s  = {1'b0, ptr_r} + 3'(k);
      cand_s = (sum_s >= 3'(NUM_REQ)) ? req_idx_t'(sum_s - 3'(NUM_REQ)) : req_idx_t'(sum_s);
      if (!found_s && en && rst_n && req_pad_s[cand_s]) begin
        found_s             = 1'b1;
        idx_s               = cand_s;
        grant_pad_s[cand_s] = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  // pointer follows the last winner
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r <= LAST_IDX;
    end else if (found_s) begin
      ptr_r <= idx_s;
    end else begin
      ptr_r <= ptr_r;
    end
  end

  assign grant       = grant_pad_s[NUM_REQ-1:0];
  assign grant_idx   = idx_s;
  assign grant_valid = found_s;

endmodule

// File: rtl/wfg_mem_arbiter.sv
// Read-port arbiter for the merged wfg stimulus memory: round-robin grant, registered csb/addr,
// in-order response routing. Optional per-requester grant counters under WFG_MEM_ARB_STATS_EN.
module wfg_mem_arbiter
  import wfg_mem_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_W     = MEM_ADDR_W,
  parameter int DATA_W     = MEM_DATA_W,
  parameter int RD_LATENCY = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      csb,
  output logic [ADDR_W-1:0]         addr,
  input  logic [DATA_W-1:0]         dout,
`ifdef WFG_MEM_ARB_STATS_EN
  input  logic                      stats_clr,
  output logic [NUM_REQ*STAT_W-1:0] grant_cnt,
`endif
  output logic                      busy
);

  logic [NUM_REQ-1:0]      grant_s;
  req_idx_t                grant_idx_s;
  logic                    accept_s;
  logic [ADDR_W-1:0]       sel_addr_s;
  logic                    csb_r;
  logic [ADDR_W-1:0]       addr_r;
  inflight_t [RD_LATENCY:0] pipe_r;
  logic [MAX_REQ-1:0]      rsp_oh_s;
  logic [NUM_REQ-1:0]      rsp_valid_r;
  logic [DATA_W-1:0]       rsp_data_r;
  logic                    busy_s;

  wfg_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .req         (req_valid),
    .grant       (grant_s),
    .grant_idx   (grant_idx_s),
    .grant_valid (accept_s)
  );

  assign req_ready = grant_s;

  // address of the granted requester; flat, bank bit is not special-cased
  always_comb begin
    sel_addr_s = {ADDR_W{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_s[i]) begin
        sel_addr_s = req_addr[i*ADDR_W +: ADDR_W];
      end else begin
        sel_addr_s = sel_addr_s;
      end
    end
  end

  // memory command register; addr holds when idle to avoid toggling
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csb_r  <= 1'b1;
      addr_r <= {ADDR_W{1'b0}};
    end else if (accept_s) begin
      csb_r  <= 1'b0;
      addr_r <= sel_addr_s;
    end else begin
      csb_r  <= 1'b1;
      addr_r <= addr_r;
    end
  end

  // in-flight tracker: stage k holds the read accepted k edges ago
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_r <= '0;
    end else begin
      pipe_r[0] <= '{valid: accept_s, id: grant_idx_s};
      for (int s = 1; s <= RD_LATENCY; s++) begin
        pipe_r[s] <= pipe_r[s-1];
      end
    end
  end

  assign rsp_oh_s = idx_to_onehot(pipe_r[RD_LATENCY].id);

  // capture memory data when the oldest in-flight read is due
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_r <= {NUM_REQ{1'b0}};
      rsp_data_r  <= {DATA_W{1'b0}};
    end else if (pipe_r[RD_LATENCY].valid) begin
      rsp_valid_r <= rsp_oh_s[NUM_REQ-1:0];
      rsp_data_r  <= dout;
    end else begin
      rsp_valid_r <= {NUM_REQ{1'b0}};
      rsp_data_r  <= rsp_data_r;
    end
  end

  // busy while any tracker stage is occupied
  always_comb begin
    busy_s = 1'b0;
    for (int s = 0; s <= RD_LATENCY; s++) begin
      busy_s = busy_s | pipe_r[s].valid;
    end
  end

  assign csb       = csb_r;
  assign addr      = addr_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_data  = rsp_data_r;
  assign busy      = busy_s;

`ifdef WFG_MEM_ARB_STATS_EN
  logic [STAT_W-1:0] cnt_r [NUM_REQ];

  // saturating grant counters; clear wins over a same-cycle accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        cnt_r[i] <= {STAT_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (stats_clr) begin
          cnt_r[i] <= {STAT_W{1'b0}};
        end else if (accept_s && grant_s[i]) begin
          cnt_r[i] <= sat_inc(cnt_r[i]);
        end else begin
          cnt_r[i] <= cnt_r[i];
        end
      end
    end
  end

  // pack counters onto the flat output
  always_comb begin
    grant_cnt = {(NUM_REQ*STAT_W){1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      grant_cnt[i*STAT_W +: STAT_W] = cnt_r[i];
    end
  end
`endif

endmodule

// File: tb/tb_wfg_mem_arbiter.sv
// Self-checking bench for wfg_mem_arbiter: a transaction-level model checked every cycle
// plus directed literal expectations; stats checks compile in with WFG_MEM_ARB_STATS_EN.
module tb_wfg_mem_arbiter;
  import wfg_mem_pkg::*;

  localparam int NR = 2;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int RL = 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              en = 1'b0;
  logic [NR-1:0]     req_valid = '0;
  logic [NR*AW-1:0]  req_addr = '0;
  logic [NR-1:0]     req_ready;
  logic [NR-1:0]     rsp_valid;
  logic [DW-1:0]     rsp_data;
  logic              csb;
  logic [AW-1:0]     addr;
  logic [DW-1:0]     dout = '0;
  logic              busy;
`ifdef WFG_MEM_ARB_STATS_EN
  logic              stats_clr = 1'b0;
  logic [NR*16-1:0]  grant_cnt;
`endif

  int checks = 0;
  int failures = 0;

  wfg_mem_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(RL)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .csb(csb), .addr(addr),
    .dout(dout),
`ifdef WFG_MEM_ARB_STATS_EN
    .stats_clr(stats_clr), .grant_cnt(grant_cnt),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  // two 512-word banks behind addr[9]
  logic [31:0] mem0 [512];
  logic [31:0] mem1 [512];

  function automatic logic [31:0] mem_read(input logic [9:0] a);
    return a[9] ? mem1[a[8:0]] : mem0[a[8:0]];
  endfunction

  always @(posedge clk) begin
    if (!csb) dout <= mem_read(addr);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct { int id; logic [31:0] data; int due; } pend_t;
  pend_t         pending[$];
  int            m_ptr;
  int            edge_n = 0;
  logic          exp_csb;
  logic [AW-1:0] exp_addr;
  logic [NR-1:0] exp_rsp_valid;
  logic [DW-1:0] exp_rsp_data;
  int            m_cnt [NR];

  function automatic int model_pick(input int ptr, input logic e, input logic [NR-1:0] v);
    if (!e) return -1;
    for (int k = 1; k <= NR; k++) begin
      if (v[(ptr + k) % NR]) return (ptr + k) % NR;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = NR - 1;
    exp_csb = 1'b1;
    exp_addr = '0;
    exp_rsp_valid = '0;
    exp_rsp_data = '0;
    pending.delete();
    for (int i = 0; i < NR; i++) m_cnt[i] = 0;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_reset();
      end else begin
        int g;
        g = model_pick(m_ptr, en, req_valid);
        edge_n++;
        exp_rsp_valid = '0;
        if (pending.size() > 0 && pending[0].due == edge_n) begin
          exp_rsp_valid[pending[0].id] = 1'b1;
          exp_rsp_data = pending[0].data;
          void'(pending.pop_front());
        end
        if (g >= 0) begin
          exp_csb = 1'b0;
          exp_addr = req_addr[g*AW +: AW];
          pending.push_back('{g, mem_read(req_addr[g*AW +: AW]), edge_n + 1 + RL});
          m_ptr = g;
        end else begin
          exp_csb = 1'b1;
        end
`ifdef WFG_MEM_ARB_STATS_EN
        if (stats_clr) begin
          for (int i = 0; i < NR; i++) m_cnt[i] = 0;
        end else if (g >= 0 && m_cnt[g] < 65535) begin
          m_cnt[g] = m_cnt[g] + 1;
        end
`endif
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      begin
        logic [NR-1:0] er;
        int g;
        g = model_pick(m_ptr, en, req_valid);
        er = '0;
        if (rst_n && g >= 0) er[g] = 1'b1;
        chk("req_ready", req_ready, er);
        chk("csb", csb, exp_csb);
        chk("addr", addr, exp_addr);
        chk("rsp_valid", rsp_valid, exp_rsp_valid);
        chk("rsp_data", rsp_data, exp_rsp_data);
        chk("busy", busy, pending.size() != 0);
`ifdef WFG_MEM_ARB_STATS_EN
        for (int i = 0; i < NR; i++) chk("grant_cnt", grant_cnt[i*16 +: 16], m_cnt[i]);
`endif
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic set_addr(input int r, input logic [AW-1:0] a);
    req_addr[r*AW +: AW] = a;
  endtask

  initial begin
    for (int i = 0; i < 512; i++) begin
      mem0[i] = 32'hA000_0000 | 32'(i);
      mem1[i] = 32'hB000_0000 | 32'(i);
    end
    mem0[5] = 32'hDEAD_BEEF;

    // reset values
    en = 1'b1;
    tick(2);
    chk("rst_csb", csb, 1'b1);
    chk("rst_rsp_valid", rsp_valid, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_addr", addr, 10'h000);
    rst_n = 1'b1;
    tick(1);

    // contention: strict alternation starting at requester 0
    set_addr(0, 10'h010);
    set_addr(1, 10'h210);
    req_valid = 2'b11;
    #1 chk("ct_first_grant", req_ready, 2'b01);
    tick(4);
    req_valid = 2'b00;
    chk("ct_rsp1_valid", rsp_valid, 2'b10);
    chk("ct_rsp1_data", rsp_data, 32'hB000_0010);
    tick(1);
    chk("ct_rsp2_valid", rsp_valid, 2'b01);
    chk("ct_rsp2_data", rsp_data, 32'hA000_0010);
    tick(3);

    // single read with two-cycle latency
    set_addr(0, 10'h005);
    req_valid = 2'b01;
    #1 chk("sr_ready", req_ready, 2'b01);
    tick(1);
    req_valid = 2'b00;
    chk("sr_csb", csb, 1'b0);
    chk("sr_addr", addr, 10'h005);
    tick(1);
    chk("sr_early_valid", rsp_valid, 2'b00);
    tick(1);
    chk("sr_rsp_valid", rsp_valid, 2'b01);
    chk("sr_rsp_data", rsp_data, 32'hDEAD_BEEF);
    tick(1);
    chk("sr_pulse_end", rsp_valid, 2'b00);
    chk("sr_data_hold", rsp_data, 32'hDEAD_BEEF);
    tick(2);

    // enable drop after three accepts
    set_addr(0, 10'h020);
    req_valid = 2'b01;
    tick(3);
    en = 1'b0;
    #1 chk("en_ready_low", req_ready, 2'b00);
    tick(1);
    chk("en_busy_mid", busy, 1'b1);
    tick(1);
    chk("en_last_rsp", rsp_valid, 2'b01);
    chk("en_busy_fall", busy, 1'b0);
    req_valid = 2'b00;
    en = 1'b1;
    tick(2);

    // reset in the cycle after an accept
    set_addr(0, 10'h030);
    req_valid = 2'b01;
    tick(1);
    req_valid = 2'b00;
    rst_n = 1'b0;
    #1 chk("mr_csb", csb, 1'b1);
    chk("mr_busy", busy, 1'b0);
    tick(2);
    chk("mr_no_rsp", rsp_valid, 2'b00);
    rst_n = 1'b1;
    set_addr(1, 10'h031);
    req_valid = 2'b11;
    #1 chk("mr_grant0", req_ready, 2'b01);
    tick(1);
    req_valid = 2'b00;
    tick(3);

    // bank boundary back-to-back from requester 1
    set_addr(1, 10'h1FF);
    req_valid = 2'b10;
    tick(1);
    set_addr(1, 10'h200);
    tick(1);
    req_valid = 2'b00;
    tick(1);
    chk("bb_rsp0_valid", rsp_valid, 2'b10);
    chk("bb_rsp0_data", rsp_data, 32'hA000_01FF);
    tick(1);
    chk("bb_rsp1_data", rsp_data, 32'hB000_0000);
    tick(2);

`ifdef WFG_MEM_ARB_STATS_EN
    stats_clr = 1'b1;
    tick(1);
    stats_clr = 1'b0;
    req_valid = 2'b01;
    tick(5);
    req_valid = 2'b10;
    tick(3);
    req_valid = 2'b00;
    chk("st_counts", grant_cnt, {16'd3, 16'd5});
    stats_clr = 1'b1;
    tick(1);
    stats_clr = 1'b0;
    req_valid = 2'b01;
    tick(65534);
    chk("st_preload", grant_cnt[15:0], 16'hFFFE);
    tick(3);
    chk("st_saturate", grant_cnt[15:0], 16'hFFFF);
    stats_clr = 1'b1;
    tick(1);
    stats_clr = 1'b0;
    req_valid = 2'b00;
    chk("st_clr_accept", grant_cnt[15:0], 16'h0000);
    tick(3);
`endif

    tick(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
